// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage feeding the opcode decoder / control unit.
//   Holds the PC, runs a req/ready handshake to instruction memory and
//   presents each fetched instruction in a registered IF/ID output with
//   stall hold (through a one-entry skid buffer) and redirect flush.
//
// Parameters
//   PC_W      PC / instruction-memory address width (word addressed)
//   INSTR_W   instruction width; opCode is the top 4 bits
//   RESET_PC  PC loaded on reset
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   stall                 decode not ready: IF/ID holds
//   redirect, redirect_pc taken branch/jump: flush, refetch from redirect_pc
//   imem_req, imem_addr   registered request to instruction memory
//   imem_ready,imem_rdata memory completes the request with this data
//   if_valid, if_instr    IF/ID register contents
//   if_pc, if_pc_plus1    PC of if_instr and PC+1 (both modulo 2^PC_W)
//   opCode                if_instr[INSTR_W-1 -: 4], not gated by if_valid
//
// Optional feature (macro FETCH_PERF_EN)
//   perf_fetched  saturating count of accepted, non-discarded fetches
//   perf_flushed  saturating count of redirects that killed live work
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int              PC_W     = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic [PC_W-1:0]    if_pc_plus1,
    output logic [3:0]         opCode
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_flushed
`endif
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } stateType;

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    stateType            state;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     skidPc;
    logic [INSTR_W-1:0]  skidInstr;
    logic [PC_W-1:0]     dropTarget;
    logic [PC_W-1:0]     dropNext;
    logic                accept;
    logic                loadOk;

    assign accept   = imem_req && imem_ready;
    assign loadOk   = !if_valid || !stall;
    // A redirect arriving in the same cycle as the dropped data wins.
    assign dropNext = redirect ? redirect_pc : dropTarget;

    // pc is the address of the outstanding (or next) request, so the
    // address is registered and stays put until the request completes.
    assign imem_addr = pc;

    // ---- IF/ID stage boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            skidInstr  <= '0;
            skidPc     <= '0;
            dropTarget <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        imem_req <= 1'b1;
                        if (accept || !imem_req) begin
                            // Data (if any) is discarded; nothing left in flight.
                            pc <= redirect_pc;
                        end else begin
                            // In-flight request cannot be cancelled: wait it out.
                            dropTarget <= redirect_pc;
                            state      <= DROP;
                        end
                    end else if (accept) begin
                        pc <= pc + PC_ONE;
                        if (loadOk) begin
                            if_instr <= imem_rdata;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            imem_req <= 1'b1;
                        end else begin
                            skidInstr <= imem_rdata;
                            skidPc    <= pc;
                            imem_req  <= 1'b0;
                            state     <= HOLD;
                        end
                    end else begin
                        if (!stall) begin
                            if_valid <= 1'b0;
                        end
                        imem_req <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        pc       <= redirect_pc;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end else if (!stall) begin
                        if_instr <= skidInstr;
                        if_pc    <= skidPc;
                        if_valid <= 1'b1;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                DROP: begin
                    if_valid <= 1'b0;
                    if (imem_ready) begin
                        pc       <= dropNext;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end else begin
                        dropTarget <= dropNext;
                    end
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b0;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

    assign if_pc_plus1 = if_pc + PC_ONE;
    assign opCode      = if_instr[INSTR_W-1 -: 4];

`ifdef FETCH_PERF_EN
    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic fetchedEvt;
    logic flushedEvt;

    assign fetchedEvt = accept && (state == FETCH) && !redirect;
    // In DROP the request is already doomed, so a newer redirect kills nothing.
    assign flushedEvt = redirect && (state != DROP) && (if_valid || imem_req);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (fetchedEvt) perf_fetched <= satInc(perf_fetched);
            if (flushedEvt) perf_flushed <= satInc(perf_flushed);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus1;
    logic [3:0]  opCode;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_flushed;
`endif

    int nCmp = 0;
    int nErr = 0;

    fetch_stage #(
        .PC_W    (16),
        .INSTR_W (16),
        .RESET_PC(16'h0010)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc_plus1(if_pc_plus1),
        .opCode     (opCode)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        rd;
        logic [15:0] rpc;
        logic        rdy;
        logic [15:0] dat;
        logic        eReq;
        logic [15:0] eAddr;
        logic        eValid;
        logic [15:0] ePc;
        logic [15:0] eInstr;
    } vecT;

    vecT vecs[17];

    // Distinct word per address (odd multiplier is a bijection mod 2^16).
    function automatic logic [15:0] memWord(input logic [15:0] a);
        return 16'(a * 16'h9E37 + 16'h3C1F);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic st, input logic rd, input logic [15:0] rpc,
                       input logic rdy, input logic [15:0] dat);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        imem_rdata  = dat;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_ready  = 1'b0;
        imem_rdata  = 16'h0000;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("rstReq",   16'(imem_req), 16'h0000);
        chk("rstAddr",  imem_addr,     16'h0010);
        chk("rstValid", 16'(if_valid), 16'h0000);
        chk("rstInstr", if_instr,      16'h0000);
        chk("rstPc",    if_pc,         16'h0000);
    endtask

    function automatic vecT mk(input logic st, input logic rd, input logic [15:0] rpc,
                               input logic rdy, input logic [15:0] dat,
                               input logic er, input logic [15:0] ea, input logic ev,
                               input logic [15:0] ep, input logic [15:0] ei);
        vecT v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.dat = dat;
        v.eReq = er; v.eAddr = ea; v.eValid = ev; v.ePc = ep; v.eInstr = ei;
        return v;
    endfunction

    initial begin
        int          consumed;
        logic [15:0] expPc;
        logic        v, rq, st, rd, rdy;
        logic [15:0] p, ins, a, rpc;

        //             st    rd    rpc       rdy   dat       req   addr      vld   pc        instr
        vecs[0]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0000, 16'h0000);
        vecs[1]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'hA010, 1'b1, 16'h0011, 1'b1, 16'h0010, 16'hA010);
        vecs[2]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'hB011, 1'b1, 16'h0012, 1'b1, 16'h0011, 16'hB011);
        vecs[3]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'hC012, 1'b0, 16'h0013, 1'b1, 16'h0011, 16'hB011);
        vecs[4]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 16'h7777, 1'b0, 16'h0013, 1'b1, 16'h0011, 16'hB011);
        vecs[5]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777, 1'b1, 16'h0013, 1'b1, 16'h0012, 16'hC012);
        vecs[6]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h7777, 1'b1, 16'h0013, 1'b0, 16'h0000, 16'h0000);
        vecs[7]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 16'h7777, 1'b1, 16'h0013, 1'b0, 16'h0000, 16'h0000);
        vecs[8]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'hD013, 1'b1, 16'h0014, 1'b1, 16'h0013, 16'hD013);
        vecs[9]  = mk(1'b1, 1'b1, 16'h0040, 1'b1, 16'hE014, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000);
        vecs[10] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h7777, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000);
        vecs[11] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'hF040, 1'b1, 16'h0041, 1'b1, 16'h0040, 16'hF040);
        vecs[12] = mk(1'b0, 1'b1, 16'h0080, 1'b0, 16'h7777, 1'b1, 16'h0041, 1'b0, 16'h0000, 16'h0000);
        vecs[13] = mk(1'b0, 1'b1, 16'h0090, 1'b0, 16'h7777, 1'b1, 16'h0041, 1'b0, 16'h0000, 16'h0000);
        vecs[14] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 16'h7777, 1'b1, 16'h0041, 1'b0, 16'h0000, 16'h0000);
        vecs[15] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b1, 16'h0090, 1'b0, 16'h0000, 16'h0000);
        vecs[16] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2090, 1'b1, 16'h0091, 1'b1, 16'h0090, 16'h2090);

        doReset();

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].rdy, vecs[i].dat);
            chk($sformatf("vec%0d.req", i),   16'(imem_req), 16'(vecs[i].eReq));
            chk($sformatf("vec%0d.addr", i),  imem_addr,     vecs[i].eAddr);
            chk($sformatf("vec%0d.valid", i), 16'(if_valid), 16'(vecs[i].eValid));
            if (vecs[i].eValid) begin
                chk($sformatf("vec%0d.pc", i),     if_pc,       vecs[i].ePc);
                chk($sformatf("vec%0d.instr", i),  if_instr,    vecs[i].eInstr);
                chk($sformatf("vec%0d.opCode", i), 16'(opCode), 16'(vecs[i].eInstr[15:12]));
                chk($sformatf("vec%0d.plus1", i),  if_pc_plus1, 16'(vecs[i].ePc + 16'd1));
            end
        end

        // Memory returns 0x1234 for addr 5 while the IF/ID entry is stalled.
        cyc(1'b0, 1'b1, 16'h0004, 1'b1, 16'h7777);
        chk("skid.addr4", imem_addr, 16'h0004);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444);
        chk("skid.pc4", if_pc, 16'h0004);
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234);
        chk("skid.reqLow",   16'(imem_req), 16'h0000);
        chk("skid.holdInst", if_instr,      16'h4444);
        chk("skid.holdVld",  16'(if_valid), 16'h0001);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h7777);
        chk("skid.instr",  if_instr,      16'h1234);
        chk("skid.pc",     if_pc,         16'h0005);
        chk("skid.opCode", 16'(opCode),   16'h0001);
        chk("skid.resume", imem_addr,     16'h0006);
        chk("skid.req",    16'(imem_req), 16'h0001);

        // Redirect while memory is stuck on addr 8.
        cyc(1'b0, 1'b1, 16'h0008, 1'b1, 16'h7777);
        cyc(1'b0, 1'b1, 16'h0040, 1'b0, 16'h7777);
        chk("drop.addrHeld", imem_addr, 16'h0008);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0, 16'h7777);
        chk("drop.addrHeld2", imem_addr,     16'h0008);
        chk("drop.noValid",   16'(if_valid), 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h9999);
        chk("drop.newAddr", imem_addr,     16'h0040);
        chk("drop.discard", 16'(if_valid), 16'h0000);

        // PC wrap.
        cyc(1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h7777);
        chk("wrap.addrFFFF", imem_addr, 16'hFFFF);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'hABCD);
        chk("wrap.pc",    if_pc,       16'hFFFF);
        chk("wrap.plus1", if_pc_plus1, 16'h0000);
        chk("wrap.addr0", imem_addr,   16'h0000);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0123);
        chk("wrap.pc0",   if_pc,     16'h0000);
        chk("wrap.addr1", imem_addr, 16'h0001);

        // Async reset in the middle of HOLD.
        doReset();
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5010);
        cyc(1'b1, 1'b0, 16'h0000, 1'b1, 16'h5011);
        chk("hold.req",   16'(imem_req), 16'h0000);
        chk("hold.valid", 16'(if_valid), 16'h0001);
`ifdef FETCH_PERF_EN
        chk("hold.perfFetched", perf_fetched, 16'h0002);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("midRst.req",   16'(imem_req), 16'h0000);
        chk("midRst.valid", 16'(if_valid), 16'h0000);
        chk("midRst.instr", if_instr,      16'h0000);
        chk("midRst.pc",    if_pc,         16'h0000);
        chk("midRst.addr",  imem_addr,     16'h0010);
`ifdef FETCH_PERF_EN
        chk("midRst.perfFetched", perf_fetched, 16'h0000);
        chk("midRst.perfFlushed", perf_flushed, 16'h0000);
`endif
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000);
        chk("restart.addr10", imem_addr, 16'h0010);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1, memWord(16'h0010));
        chk("restart.addr11", imem_addr, 16'h0011);
        chk("restart.pc",     if_pc,     16'h0010);

        // Randomized run against a program-order stream model.
        doReset();
        expPc    = 16'h0010;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            v   = if_valid;
            p   = if_pc;
            ins = if_instr;
            rq  = imem_req;
            a   = imem_addr;
            if (v) begin
                chk("rnd.opCode", 16'(opCode), 16'(ins[15:12]));
                chk("rnd.plus1",  if_pc_plus1, 16'(p + 16'd1));
            end
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 5);
            rpc = 16'($urandom);
            rdy = ($urandom_range(0, 99) < 70);
            cyc(st, rd, rpc, rdy, memWord(a));
            if (rd) begin
                chk("rnd.flush", 16'(if_valid), 16'h0000);
                expPc = rpc;
            end else begin
                if (v && !st) begin
                    chk("rnd.streamPc",    p,   expPc);
                    chk("rnd.streamInstr", ins, memWord(p));
                    expPc = 16'(p + 16'd1);
                    consumed++;
                end
                if (v && st) begin
                    chk("rnd.holdVld",   16'(if_valid), 16'h0001);
                    chk("rnd.holdPc",    if_pc,         p);
                    chk("rnd.holdInstr", if_instr,      ins);
                end
            end
            if (rq && !rdy) begin
                chk("rnd.reqHeld",  16'(imem_req), 16'h0001);
                chk("rnd.addrHeld", imem_addr,     a);
            end
        end
        chk("rnd.progress", 16'(consumed > 200), 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the opcode decoder / control unit.
- Holds the PC and runs a req/ready handshake to instruction memory.
- Presents each fetched instruction, its PC and its 4-bit opCode field in a registered IF/ID output, with stall hold and redirect flush from branch/jump resolution.

Parameters:
- PC_W, 16, width of the PC and instruction-memory address (word addressed).
- INSTR_W, 16, instruction width; opCode is instr[INSTR_W-1 -: 4].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  decode not ready; IF/ID output must hold.
- redirect  in  1  taken branch or jump; flush and refetch from redirect_pc.
- redirect_pc  in  PC_W  new fetch address.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  PC_W  request address; equals the PC of the request.
- imem_ready  in  1  memory returns imem_rdata this cycle; completes the request.
- imem_rdata  in  INSTR_W  instruction word, valid when imem_ready=1.
- if_valid  out  1  IF/ID register holds a real instruction.
- if_instr  out  INSTR_W  registered instruction.
- if_pc  out  PC_W  PC of if_instr.
- if_pc_plus1  out  PC_W  if_pc+1, for branch and jump target computation.
- opCode  out  4  if_instr[INSTR_W-1 -: 4]; feeds the control unit.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, imem_req=0, if_valid=0, if_instr=0, if_pc=0, skid buffer empty. The first request is issued in the first cycle after rst_n rises.
- Reset mid-request: the outstanding memory request is abandoned. Memory must tolerate this.
- Request rule: imem_req and imem_addr come from registers. While imem_req=1, imem_addr stays stable until imem_ready=1.
- Definitions:
  - load_ok = !if_valid || !stall.
  - accept = imem_req && imem_ready.

States:
- FETCH: imem_req=1, imem_addr=pc.
  - accept && load_ok: if_instr=imem_rdata, if_pc=pc, if_valid=1; pc=pc+1; remain in FETCH and issue the next request the following cycle. Sustained throughput is one instruction per cycle with a zero-wait memory.
  - accept && !load_ok: capture into the skid buffer (instr, pc); pc=pc+1; imem_req=0; go to HOLD.
  - !accept && !stall: if_valid=0 (bubble).
  - !accept && stall: IF/ID holds.
- HOLD: imem_req=0. When stall=0, move the skid buffer into IF/ID (if_valid=1) and go to FETCH.
- DROP: imem_req=1 with the old address, held until imem_ready. The returned data is discarded, then go to FETCH with pc=the latched redirect target. if_valid stays 0 throughout.

Redirect (highest priority, overrides stall):
- Always: if_valid=0 next cycle, skid buffer discarded, pc=redirect_pc.
- In FETCH with !imem_ready: latch the target and go to DROP. The in-flight request is never cancelled.
- In FETCH with imem_ready: discard the data and go to FETCH at redirect_pc.
- In HOLD: go to FETCH.
- In DROP: update the latched target to the newest redirect_pc.

Other rules:
- PC arithmetic is modulo 2^PC_W; 0xFFFF+1 wraps to 0x0000.
- if_pc_plus1 wraps the same way.
- opCode is purely combinational from if_instr. It is not gated by if_valid, so the consumer qualifies it with if_valid.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports perf_fetched[15:0] and perf_flushed[15:0].
  - perf_fetched increments on every accept that is not discarded.
  - perf_flushed increments on every redirect that kills a valid IF/ID entry, a skid entry, or an in-flight request.
  - Both counters saturate at 0xFFFF and are cleared by rst_n.
- Undefined: no such ports or logic; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0x0010 and zero-wait memory, stall=0 -> imem_addr sequence 0x0010, 0x0011, 0x0012 on consecutive cycles; if_valid=1 from the 2nd cycle after reset release; if_pc tracks with 1-cycle lag; opCode=imem_rdata[15:12].
- Memory returns 0x1234 at addr 0x0005 while stall=1 and if_valid=1 -> IF/ID holds its old value; state HOLD, imem_req=0. When stall drops: if_instr=0x1234, if_pc=0x0005, opCode=4'b0001. Fetch resumes at 0x0006.
- redirect=1, redirect_pc=0x0040 while memory is stalled (ready=0) on addr 0x0008 -> imem_addr stays 0x0008 until ready; data discarded, if_valid=0; next request is to 0x0040.
- redirect and stall asserted together with a valid IF/ID -> if_valid=0 the next cycle; the next valid if_pc=0x0040.
- PC at 0xFFFF with zero-wait memory -> next imem_addr=0x0000; if_pc_plus1 for if_pc=0xFFFF is 0x0000.
- rst_n pulsed low mid-HOLD with FETCH_PERF_EN defined -> all outputs return to reset values immediately; perf counters read 0; fetch restarts at RESET_PC.
